// File: rtl/cond_logic.sv
// ARM-style condition check and flag register with a stall handshake for multi-cycle ALU ops.
// Single-cycle ops write Flags one edge after issue; multi-cycle ops hold Stall until ALUDone.
module cond_logic (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] Cond,
  input  logic [3:0] ALUFlags,
  input  logic [1:0] FlagW,
  input  logic       PCS,
  input  logic       RegW,
  input  logic       MemW,
  input  logic       NoWrite,
  input  logic       Start,
  input  logic       ALUDone,
  output logic       PCSrc,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       CondEx,
  output logic       Stall,
  output logic [3:0] Flags
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t     state;
  logic [1:0] pend_flagw;
  logic       pend_pcs;
  logic       pend_regw;
  logic       pend_memw;
  logic       cond_ex;

  logic flag_n, flag_z, flag_c, flag_v;
  assign {flag_n, flag_z, flag_c, flag_v} = Flags;

  always_comb begin
    cond_ex = 1'b0;
    case (Cond)
      4'b0000: cond_ex = flag_z;
      4'b0001: cond_ex = !flag_z;
      4'b0010: cond_ex = flag_c;
      4'b0011: cond_ex = !flag_c;
      4'b0100: cond_ex = flag_n;
      4'b0101: cond_ex = !flag_n;
      4'b0110: cond_ex = flag_v;
      4'b0111: cond_ex = !flag_v;
      4'b1000: cond_ex = flag_c & !flag_z;
      4'b1001: cond_ex = !flag_c | flag_z;
      4'b1010: cond_ex = (flag_n == flag_v);
      4'b1011: cond_ex = (flag_n != flag_v);
      4'b1100: cond_ex = !flag_z & (flag_n == flag_v);
      4'b1101: cond_ex = flag_z | (flag_n != flag_v);
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  assign CondEx = cond_ex;

  // Reset gates every enable and Stall so nothing leaks while the block is held.
  always_comb begin
    PCSrc    = 1'b0;
    RegWrite = 1'b0;
    MemWrite = 1'b0;
    Stall    = 1'b0;
    if (reset) begin
      case (state)
        S_IDLE: begin
          if (Start) begin
            Stall = cond_ex;
          end else begin
            PCSrc    = PCS & cond_ex;
            RegWrite = RegW & cond_ex & !NoWrite;
            MemWrite = MemW & cond_ex;
          end
        end
        S_WAIT: begin
          if (ALUDone) begin
            PCSrc    = pend_pcs;
            RegWrite = pend_regw;
            MemWrite = pend_memw;
          end else begin
            Stall = 1'b1;
          end
        end
        default: Stall = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      Flags      <= 4'b0000;
      pend_flagw <= 2'b00;
      pend_pcs   <= 1'b0;
      pend_regw  <= 1'b0;
      pend_memw  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (Start) begin
            if (cond_ex) begin
              pend_flagw <= FlagW;
              pend_pcs   <= PCS;
              pend_regw  <= RegW & !NoWrite;
              pend_memw  <= MemW;
              state      <= S_WAIT;
            end
          end else begin
            if (FlagW[1] & cond_ex) Flags[3:2] <= ALUFlags[3:2];
            if (FlagW[0] & cond_ex) Flags[1:0] <= ALUFlags[1:0];
          end
        end
        S_WAIT: begin
          // Condition already passed at issue; completion writes unconditionally.
          if (ALUDone) begin
            if (pend_flagw[1]) Flags[3:2] <= ALUFlags[3:2];
            if (pend_flagw[0]) Flags[1:0] <= ALUFlags[1:0];
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cond_logic.sv
// Randomised and directed checks of cond_logic against a transaction-level reference model.
module tb_cond_logic;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] Cond, ALUFlags;
  logic [1:0] FlagW;
  logic       PCS, RegW, MemW, NoWrite, Start, ALUDone;
  logic       PCSrc, RegWrite, MemWrite, CondEx, Stall;
  logic [3:0] Flags;

  int total = 0;
  int bad   = 0;

  // Reference model: flags plus an optional in-flight operation.
  typedef struct {
    bit       valid;
    bit [1:0] flagw;
    bit       pcs, regw, memw;
  } op_t;

  bit [3:0] m_flags;
  op_t      m_op;

  always #5 clk = ~clk;

  cond_logic dut (
    .clk(clk), .reset(reset), .Cond(Cond), .ALUFlags(ALUFlags), .FlagW(FlagW),
    .PCS(PCS), .RegW(RegW), .MemW(MemW), .NoWrite(NoWrite), .Start(Start),
    .ALUDone(ALUDone), .PCSrc(PCSrc), .RegWrite(RegWrite), .MemWrite(MemWrite),
    .CondEx(CondEx), .Stall(Stall), .Flags(Flags)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit cond_pass(input bit [3:0] c, input bit [3:0] f);
    bit n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return cy;
      4'h3: return !cy;
      4'h4: return n;
      4'h5: return !n;
      4'h6: return v;
      4'h7: return !v;
      4'h8: return cy && !z;
      4'h9: return !cy || z;
      4'hA: return n == v;
      4'hB: return n != v;
      4'hC: return !z && (n == v);
      4'hD: return z || (n != v);
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit [3:0] merge(input bit [3:0] old, input bit [3:0] nw, input bit [1:0] w);
    bit [3:0] mask;
    mask = {w[1], w[1], w[0], w[0]};
    return (nw & mask) | (old & ~mask);
  endfunction

  task automatic model_reset();
    m_flags = 4'b0000;
    m_op    = '{valid: 1'b0, flagw: 2'b00, pcs: 1'b0, regw: 1'b0, memw: 1'b0};
  endtask

  // Inputs are already driven; check combinational outputs, clock once, check Flags.
  task automatic cycle();
    bit cx, e_pc, e_rw, e_mw, e_st;
    #1;
    cx = cond_pass(Cond, m_flags);
    {e_pc, e_rw, e_mw, e_st} = 4'b0000;
    if (reset) begin
      if (m_op.valid) begin
        if (ALUDone) {e_pc, e_rw, e_mw} = {m_op.pcs, m_op.regw, m_op.memw};
        else e_st = 1'b1;
      end else if (Start) begin
        e_st = cx;
      end else begin
        e_pc = PCS && cx;
        e_rw = RegW && cx && !NoWrite;
        e_mw = MemW && cx;
      end
    end
    check("condex",   CondEx,   cx);
    check("pcsrc",    PCSrc,    e_pc);
    check("regwrite", RegWrite, e_rw);
    check("memwrite", MemWrite, e_mw);
    check("stall",    Stall,    e_st);
    @(posedge clk);
    if (reset) begin
      if (m_op.valid) begin
        if (ALUDone) begin
          m_flags    = merge(m_flags, ALUFlags, m_op.flagw);
          m_op.valid = 1'b0;
        end
      end else if (Start) begin
        if (cx) m_op = '{valid: 1'b1, flagw: FlagW, pcs: PCS, regw: RegW && !NoWrite, memw: MemW};
      end else if (cx) begin
        m_flags = merge(m_flags, ALUFlags, FlagW);
      end
    end
    #1;
    check("flags", Flags, m_flags);
  endtask

  initial begin
    reset = 1'b0; Cond = 4'hE; RegW = 1'b1; ALUFlags = 4'h0; FlagW = 2'b00;
    PCS = 1'b0; MemW = 1'b0; NoWrite = 1'b0; Start = 1'b0; ALUDone = 1'b0;
    model_reset();
    #2;
    check("rst_regwrite", RegWrite, 1'b0);
    check("rst_flags", Flags, 4'h0);
    cycle();
    cycle();

    // Release: AL passes, EQ fails against cleared flags.
    reset = 1'b1;
    #1 check("rel_regwrite", RegWrite, 1'b1);
    cycle();
    Cond = 4'h0; RegW = 1'b0;
    #1 check("rel_eq", CondEx, 1'b0);
    cycle();

    Cond = 4'hE; FlagW = 2'b11; ALUFlags = 4'b0110;
    cycle();
    check("flags_0110", Flags, 4'b0110);
    FlagW = 2'b00; Cond = 4'h0;
    #1 check("eq_after", CondEx, 1'b1);
    cycle();
    Cond = 4'hC;
    #1 check("gt_after", CondEx, 1'b0);
    cycle();

    Cond = 4'hE; FlagW = 2'b01; ALUFlags = 4'b1111;
    cycle();
    check("flags_cv_only", Flags, 4'b0111);
    FlagW = 2'b10; ALUFlags = 4'b1000;
    cycle();
    check("flags_nz_only", Flags, 4'b1011);

    // Multi-cycle op: issue cycle plus three waiting cycles stalled.
    Cond = 4'hE; RegW = 1'b1; FlagW = 2'b11; Start = 1'b1; ALUFlags = 4'b0100;
    for (int i = 0; i < 4; i++) begin
      #1 check("mc_stall", Stall, 1'b1);
      check("mc_noreg", RegWrite, 1'b0);
      cycle();
      Start = 1'b0; Cond = 4'hF;
    end
    ALUDone = 1'b1;
    #1 check("mc_done_stall", Stall, 1'b0);
    check("mc_done_reg", RegWrite, 1'b1);
    cycle();
    check("mc_flags", Flags, 4'b0100);
    ALUDone = 1'b0; RegW = 1'b0; FlagW = 2'b00; Cond = 4'hE;

    // Clear Z, then a failing multi-cycle issue is squashed.
    FlagW = 2'b11; ALUFlags = 4'h0;
    cycle();
    Start = 1'b1; Cond = 4'h0; RegW = 1'b1; MemW = 1'b1; PCS = 1'b1; ALUFlags = 4'hF;
    #1 check("sq_stall", Stall, 1'b0);
    check("sq_reg", RegWrite, 1'b0);
    cycle();
    check("sq_flags", Flags, 4'h0);
    Start = 1'b0; Cond = 4'hE; RegW = 1'b0; MemW = 1'b0; PCS = 1'b0; FlagW = 2'b00;
    #1 check("sq_idle", Stall, 1'b0);
    cycle();

    // Reset in WAIT aborts the pending op.
    Start = 1'b1; Cond = 4'hE; RegW = 1'b1; FlagW = 2'b11; ALUFlags = 4'hF;
    cycle();
    Start = 1'b0;
    cycle();
    reset = 1'b0;
    model_reset();
    #1 check("abort_stall", Stall, 1'b0);
    check("abort_flags", Flags, 4'h0);
    cycle();
    reset = 1'b1; ALUDone = 1'b1; Cond = 4'hF;
    #1 check("abort_noreg", RegWrite, 1'b0);
    check("abort_nostall", Stall, 1'b0);
    cycle();
    check("abort_flags2", Flags, 4'h0);

    for (int i = 0; i < 3000; i++) begin
      Cond     = 4'($urandom);
      ALUFlags = 4'($urandom);
      FlagW    = 2'($urandom);
      PCS      = 1'($urandom);
      RegW     = 1'($urandom);
      MemW     = 1'($urandom);
      NoWrite  = ($urandom_range(3) == 0);
      Start    = ($urandom_range(3) == 0);
      ALUDone  = ($urandom_range(2) == 0);
      if ($urandom_range(99) == 0) begin
        reset = 1'b0;
        model_reset();
      end else begin
        reset = 1'b1;
      end
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cond_logic.md
COND_LOGIC -- requirements
Module: cond_logic

Interface
REQ-001 The module SHALL have the port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 The module SHALL have the port reset, input, 1 bit: asynchronous, active-low reset.
REQ-003 The module SHALL have the port Cond, input, 4 bits: ARM condition field of the current instruction.
REQ-004 The module SHALL have the port ALUFlags, input, 4 bits: {N,Z,C,V} produced by the ALU for the current operation.
REQ-005 The module SHALL have the port FlagW, input, 2 bits: bit1 requests an N/Z update, bit0 requests a C/V update.
REQ-006 The module SHALL have the ports PCS, RegW, MemW and NoWrite, input, 1 bit each: the decoder's unconditional PC, register and memory write requests, and the compare-only suppression.
REQ-007 The module SHALL have the port Start, input, 1 bit: the current ALU operation is multi-cycle (DIV, SMUL/UMUL, FP ops).
REQ-008 The module SHALL have the port ALUDone, input, 1 bit: the multi-cycle ALU result and flags are valid this cycle.
REQ-009 The module SHALL have the ports PCSrc, RegWrite and MemWrite, output, 1 bit each: the gated write enables.
REQ-010 The module SHALL have the port CondEx, output, 1 bit: the condition passed.
REQ-011 The module SHALL have the port Stall, output, 1 bit: the fetch/decode front end is held.
REQ-012 The module SHALL have the port Flags, output, 4 bits: the architectural {N,Z,C,V} register.

Function
REQ-013 The module SHALL evaluate CondEx combinationally from Cond and the registered Flags (never from ALUFlags), with the following encodings:
- 0000 EQ: Z
- 0001 NE: !Z
- 0010 CS: C
- 0011 CC: !C
- 0100 MI: N
- 0101 PL: !N
- 0110 VS: V
- 0111 VC: !V
- 1000 HI: C&!Z
- 1001 LS: !C|Z
- 1010 GE: N==V
- 1011 LT: N!=V
- 1100 GT: !Z&(N==V)
- 1101 LE: Z|(N!=V)
- 1110 AL: 1
- 1111: 0
REQ-014 The module SHALL implement a two-state machine, IDLE and WAIT; reset SHALL enter IDLE.
REQ-015 In IDLE with Start=0, the outputs SHALL be:
- PCSrc=PCS&CondEx
- RegWrite=RegW&CondEx&!NoWrite
- MemWrite=MemW&CondEx
- Stall=0
REQ-016 In IDLE with Start=0, Flags[3:2] SHALL load ALUFlags[3:2] at the clock edge when FlagW[1]&CondEx, and Flags[1:0] SHALL load ALUFlags[1:0] when FlagW[0]&CondEx; unselected bits SHALL hold.
REQ-017 In IDLE with Start=1 and CondEx=1, the module SHALL behave as follows:
- PCSrc, RegWrite, MemWrite SHALL be 0 and Stall SHALL be 1 in that cycle.
- The module SHALL capture pending copies of FlagW, PCS, RegW&!NoWrite and MemW, and go to WAIT.
- Flags SHALL NOT change.
REQ-018 In IDLE with Start=1 and CondEx=0, the instruction SHALL be squashed: all enables 0, Stall=0, no flag change, remain IDLE.
REQ-019 In WAIT with ALUDone=0, the module SHALL drive Stall=1 and all enables 0, hold Flags and the pending registers, and remain in WAIT; Cond, FlagW, PCS, RegW, MemW, NoWrite and Start SHALL be ignored.
REQ-020 In WAIT with ALUDone=1, the module SHALL behave as follows:
- It SHALL drive Stall=0 and PCSrc/RegWrite/MemWrite equal to the pending copies for exactly that cycle.
- At the edge, it SHALL update Flags from ALUFlags per the pending FlagW bit rules of REQ-016 (no CondEx re-check).
- It SHALL return to IDLE.
REQ-021 ALUDone asserted while in IDLE SHALL be ignored.
REQ-022 Start and ALUDone both high in IDLE SHALL follow REQ-017 (a zero-cycle completion is not supported).
REQ-023 The latency SHALL be as follows:
- A single-cycle operation SHALL write Flags one edge after issue.
- A multi-cycle operation SHALL write Flags on the edge at which ALUDone is sampled high in WAIT.
REQ-024 All outputs except the registered Flags SHALL be combinational from state, pending registers and inputs; no output SHALL depend on ALUFlags.

Reset
REQ-025 While reset=0, the module SHALL hold the following, asynchronously:
- state=IDLE
- Flags=4'b0000
- pending registers=0
- Stall=0
REQ-026 While reset=0, PCSrc, RegWrite and MemWrite SHALL be gated to 0.
REQ-027 Reset asserted in WAIT SHALL abort the pending operation with no enable pulse and no flag write.
REQ-028 After reset release, CondEx SHALL evaluate against Flags=0000 (EQ false, NE true, AL true).

Verification
REQ-029 The bench SHALL drive reset low with Cond=1110 and RegW=1 -> RegWrite=0, Flags=0000; after release -> RegWrite=1, and Cond=0000 gives CondEx=0.
REQ-030 The bench SHALL apply FlagW=11, ALUFlags=0110 with Cond=1110 -> Flags=0110 next edge; then Cond=0000 gives CondEx=1 and Cond=1100 gives CondEx=0.
REQ-031 The bench SHALL apply FlagW=01, ALUFlags=1111 after Flags=0110 -> Flags=0111 (N/Z held); then FlagW=10, ALUFlags=1000 -> Flags=1011.
REQ-032 The bench SHALL apply Start=1, Cond=1110, RegW=1, FlagW=11, then ALUDone after 3 cycles with ALUFlags=0100 -> Stall=1 for 4 cycles, RegWrite=1 only in the ALUDone cycle, Flags=0100 after it.
REQ-033 The bench SHALL apply Start=1 with Cond=0000 while Z=0 -> no stall, no enables, Flags unchanged, state IDLE.
REQ-034 The bench SHALL assert reset mid-WAIT followed by ALUDone=1 after release -> no RegWrite pulse, Flags=0000, Stall=0.
